main_decoder: RTL and testbench

Main control decoder for the single-cycle RV32I core. It maps the 7-bit instruction opcode to the datapath control signals: branch, jump, memory write, ALU source, register write, result select, immediate-format select and ALU-op class. It sits in the control unit beside the ALU decoder, which consumes `alu_op`. Decode is purely combinational. The only clocked logic is a sticky illegal-opcode flag for debug.

---
 rtl/riscv_ctrl_pkg.sv | 29 ++
 rtl/main_decoder.sv | 105 ++++++++++
 tb/tb_main_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-unit definitions for the single-cycle RV32I core.
// Holds the opcode constants the main decoder recognises and the encodings
// of the control fields it drives (result_src, imm_src, alu_op).
package riscv_ctrl_pkg;

  // Opcodes, instr[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate-format select; S and B share a code, the extender splits them.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_J = 2'b11;

  // Writeback select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/main_decoder.sv
// Main control decoder for the single-cycle RV32I core.
// Maps the 7-bit opcode to datapath control signals. Decode is purely
// combinational and independent of rst; the only state is a sticky flag that
// remembers whether any unsupported opcode has been seen since reset.
//
// Ports:
//   clk          in   clock, used only by the sticky flag
//   rst          in   synchronous active-high reset (sticky flag only)
//   op           in   instr[6:0]
//   branch       out  conditional branch
//   jump         out  jal
//   mem_write    out  data-memory write enable
//   alu_src      out  ALU operand B: 0 = rs2, 1 = immediate
//   reg_write    out  register-file write enable
//   result_src   out  writeback select (ALU / memory / PC+4)
//   imm_src      out  immediate format (I / S-B / J)
//   alu_op       out  ALU class (add / sub / funct-decoded)
//   illegal_op   out  combinational: op is unsupported
//   illegal_seen out  registered sticky version of illegal_op
module main_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  output logic       branch,
  output logic       jump,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic       illegal_seen
);

  logic illegal_seen_q, illegal_seen_d;

  // Every field defaults to 0 so don't-care fields are never X and an
  // unsupported opcode yields an all-zero (harmless) control word.
  always_comb begin
    branch     = 1'b0;
    jump       = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALU;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (op)
      OP_LOAD: begin
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_MEM;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
      end
      OP_IMM: begin
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        alu_op     = ALUOP_FUNCT;
      end
      OP_RTYPE: begin
        reg_write  = 1'b1;
        result_src = RES_ALU;
        alu_op     = ALUOP_FUNCT;
      end
      OP_STORE: begin
        mem_write  = 1'b1;
        alu_src    = 1'b1;
        imm_src    = IMM_S;
        alu_op     = ALUOP_ADD;
      end
      OP_BRANCH: begin
        branch     = 1'b1;
        imm_src    = IMM_S;
        alu_op     = ALUOP_SUB;
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      default: illegal_op = 1'b1;
    endcase
  end

  assign illegal_seen_d = illegal_seen_q | illegal_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_main_decoder.sv
// Bench for main_decoder: directed vector table, hand-written reset/sticky
// sequences, a full opcode sweep and random opcodes against a lookup model.
module tb_main_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       branch, jump, mem_write, alu_src, reg_write;
  logic [1:0] result_src, imm_src, alu_op;
  logic       illegal_op, illegal_seen;

  main_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .branch       (branch),
    .jump         (jump),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .result_src   (result_src),
    .imm_src      (imm_src),
    .alu_op       (alu_op),
    .illegal_op   (illegal_op),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {branch, jump, mem_write, alu_src, reg_write, result_src, imm_src, alu_op}
  logic [10:0] dec;
  assign dec = {branch, jump, mem_write, alu_src, reg_write, result_src, imm_src, alu_op};

  int n_vec = 0;
  int n_err = 0;
  logic seen_m;

  // Reference: table of the six supported opcodes and their control words.
  logic [6:0]  ref_op  [6];
  logic [10:0] ref_dec [6];

  function automatic logic [11:0] model(input logic [6:0] o);
    for (int i = 0; i < 6; i++) begin
      if (ref_op[i] == o) return {1'b0, ref_dec[i]};
    end
    return {1'b1, 11'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: op=%0d got %0h expected %0h", name, op, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check decode/sticky before the edge,
  // advance the sticky model at the edge, check sticky after it.
  task automatic step(input logic [6:0] o, input logic r);
    logic [11:0] m;
    @(negedge clk);
    op  = o;
    rst = r;
    #1;
    m = model(o);
    chk("decode", {21'b0, dec}, {21'b0, m[10:0]});
    chk("illegal_op", {31'b0, illegal_op}, {31'b0, m[11]});
    chk("seen_pre", {31'b0, illegal_seen}, {31'b0, seen_m});
    @(posedge clk);
    seen_m = r ? 1'b0 : (seen_m | m[11]);
    #1;
    chk("seen_post", {31'b0, illegal_seen}, {31'b0, seen_m});
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [10:0] dec;
    logic        ill;
  } vec_t;

  vec_t vt [8];

  initial begin
    ref_op[0] = 7'd3;   ref_dec[0] = 11'b0_0_0_1_1_01_00_00;
    ref_op[1] = 7'd19;  ref_dec[1] = 11'b0_0_0_1_1_00_00_10;
    ref_op[2] = 7'd51;  ref_dec[2] = 11'b0_0_0_0_1_00_00_10;
    ref_op[3] = 7'd35;  ref_dec[3] = 11'b0_0_1_1_0_00_01_00;
    ref_op[4] = 7'd99;  ref_dec[4] = 11'b1_0_0_0_0_00_01_01;
    ref_op[5] = 7'd111; ref_dec[5] = 11'b0_1_0_0_1_10_11_00;

    vt[0] = '{7'd3,   11'b0_0_0_1_1_01_00_00, 1'b0};
    vt[1] = '{7'd19,  11'b0_0_0_1_1_00_00_10, 1'b0};
    vt[2] = '{7'd51,  11'b0_0_0_0_1_00_00_10, 1'b0};
    vt[3] = '{7'd35,  11'b0_0_1_1_0_00_01_00, 1'b0};
    vt[4] = '{7'd99,  11'b1_0_0_0_0_00_01_01, 1'b0};
    vt[5] = '{7'd111, 11'b0_1_0_0_1_10_11_00, 1'b0};
    vt[6] = '{7'd0,   11'b0,                  1'b1};
    vt[7] = '{7'd127, 11'b0,                  1'b1};

    rst    = 1'b1;
    op     = 7'd0;
    seen_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seen", {31'b0, illegal_seen}, 32'd0);

    // Directed table with hand-written expectations; sticky stays low until op=0.
    @(negedge clk);
    rst = 1'b0;
    op  = 7'd3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      op = vt[i].op;
      #1;
      chk("tbl_decode", {21'b0, dec}, {21'b0, vt[i].dec});
      chk("tbl_illegal", {31'b0, illegal_op}, {31'b0, vt[i].ill});
      chk("tbl_seen_pre", {31'b0, illegal_seen}, {31'b0, (i == 7)});
      @(posedge clk);
      #1;
      chk("tbl_seen_post", {31'b0, illegal_seen}, {31'b0, (i >= 6)});
    end
    seen_m = 1'b1;

    // Reset wins over an illegal opcode, then the flag re-arms one edge later.
    step(7'd127, 1'b1);
    chk("rst_wins", {31'b0, illegal_seen}, 32'd0);
    step(7'd127, 1'b0);
    chk("rearm", {31'b0, illegal_seen}, 32'd1);
    // Legal opcodes after reset must leave the flag low.
    step(7'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(ref_op[i], 1'b0);
    chk("legal_keeps_low", {31'b0, illegal_seen}, 32'd0);

    // Decode must not depend on an unknown rst.
    @(negedge clk);
    rst = 1'bx;
    op  = 7'd51;
    #1;
    chk("xrst_decode", {21'b0, dec}, {21'b0, 11'b0_0_0_0_1_00_00_10});
    chk("xrst_known", {31'b0, $isunknown({dec, illegal_op})}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    seen_m = 1'b0;

    // Full sweep with rst held.
    for (int o = 0; o < 128; o++) begin
      step(o[6:0], 1'b1);
      chk("sweep_known", {31'b0, $isunknown({dec, illegal_op, illegal_seen})}, 32'd0);
    end

    // Random opcodes, biased towards legal ones, with occasional reset.
    for (int k = 0; k < 400; k++) begin
      logic [6:0] o;
      if ($urandom_range(1, 0) == 1) o = ref_op[$urandom_range(5, 0)];
      else o = 7'($urandom_range(127, 0));
      step(o, ($urandom_range(15, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
